// File: rtl/panel_control_pkg.sv
// Shared encodings and limits for the washing-machine front-panel controller.
package panel_control_pkg;

    // Run state seen by the timing block.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    // Wash-model encodings.
    typedef enum logic [2:0] {
        MODEL_WASH_RINSE_SPIN = 3'd0,
        MODEL_WASH            = 3'd1,
        MODEL_WASH_RINSE      = 3'd2,
        MODEL_RINSE           = 3'd3,
        MODEL_RINSE_SPIN      = 3'd4,
        MODEL_SPIN            = 3'd5
    } model_t;

    localparam logic [2:0] MODEL_MAX     = 3'd5;
    localparam logic [2:0] WATER_MIN     = 3'd1;
    localparam logic [2:0] WATER_MAX     = 3'd5;
    localparam logic [2:0] WATER_DEFAULT = 3'd2;

    // Model selection wraps from the last programme back to the first.
    function automatic logic [2:0] next_model(input logic [2:0] m);
        return (m >= MODEL_MAX) ? 3'(MODEL_WASH_RINSE_SPIN) : m + 3'd1;
    endfunction

    // Water level wraps from the highest level back to the lowest.
    function automatic logic [2:0] next_water(input logic [2:0] w);
        return (w >= WATER_MAX) ? WATER_MIN : w + 3'd1;
    endfunction

endpackage

// File: rtl/panel_control_key_debounce.sv
// Per-key synchroniser and debouncer producing a one-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;

    // Synchronise, count consecutive differing samples, accept the new level on the last one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_raw};
            press_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q[1];
                    press_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign key_level = level_q;
    assign key_press = press_q;

endmodule

// File: rtl/panel_control.sv
// Front-panel controller: power, model/water selection, run/pause/done, buzzer, idle power-off.
module panel_control
    import panel_control_pkg::*;
#(
    parameter int unsigned     DEB_CYCLES   = 1_000_000,
    parameter int unsigned     DONE_HOLD    = 300_000_000,
    parameter longint unsigned IDLE_TIMEOUT = 64'd6_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_key,
    input  logic       start_key,
    input  logic       model_key,
    input  logic       water_key,
    input  logic       finish,
    output logic       power_light,
    output logic [1:0] run_state,
    output logic [2:0] current_model,
    output logic [2:0] current_water,
    output logic       buzzer
);

    localparam int unsigned IW = $clog2(IDLE_TIMEOUT);
    localparam int unsigned DW = $clog2(DONE_HOLD + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_HOLD - 1);

    // Accepted key levels are not needed here; only press edges drive the controller.
    logic [3:0] levels_unused;
    logic       press_pwr, press_start, press_model, press_water;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_power (
        .clk(clk), .rst_n(rst_n), .key_raw(power_key),
        .key_level(levels_unused[0]), .key_press(press_pwr)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .key_raw(start_key),
        .key_level(levels_unused[1]), .key_press(press_start)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_model (
        .clk(clk), .rst_n(rst_n), .key_raw(model_key),
        .key_level(levels_unused[2]), .key_press(press_model)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_water (
        .clk(clk), .rst_n(rst_n), .key_raw(water_key),
        .key_level(levels_unused[3]), .key_press(press_water)
    );

    run_state_t    state_q, state_d;
    logic          power_q, power_d;
    logic [2:0]    model_q, model_d;
    logic [2:0]    water_q, water_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d, idle_cnt_inc;
    logic [DW-1:0] done_cnt_q, done_cnt_d;
    logic          buzzer_q;
    logic          go_off;

    // State and settings register; buzzer follows the next state so it is high from DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            power_q    <= 1'b0;
            model_q    <= 3'(MODEL_WASH_RINSE_SPIN);
            water_q    <= WATER_DEFAULT;
            idle_cnt_q <= '0;
            done_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            power_q    <= power_d;
            model_q    <= model_d;
            water_q    <= water_d;
            idle_cnt_q <= idle_cnt_d;
            done_cnt_q <= done_cnt_d;
            buzzer_q   <= (state_d == ST_DONE);
        end
    end

    // Next-state logic: the if/else chain realises power > start > model > water priority.
    always_comb begin
        state_d      = state_q;
        power_d      = power_q;
        model_d      = model_q;
        water_d      = water_q;
        idle_cnt_d   = '0;
        done_cnt_d   = '0;
        idle_cnt_inc = idle_cnt_q + IW'(1);
        go_off       = 1'b0;

        if (press_pwr) begin
            if (power_q) go_off = 1'b1;
            else         power_d = 1'b1;
        end else if (power_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (press_start)                 state_d = ST_RUN;
                    else if (press_model)            model_d = next_model(model_q);
                    else if (press_water)            water_d = next_water(water_q);
                    else if (idle_cnt_inc == IDLE_LAST) go_off = 1'b1;
                    else                             idle_cnt_d = idle_cnt_inc;
                end
                ST_RUN: begin
                    if (finish)           state_d = ST_DONE;
                    else if (press_start) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (press_start) state_d = ST_RUN;
                end
                ST_DONE: begin
                    if (done_cnt_q == DONE_LAST) state_d = ST_IDLE;
                    else                         done_cnt_d = done_cnt_q + DW'(1);
                end
            endcase
        end

        if (go_off) begin
            power_d = 1'b0;
            state_d = ST_IDLE;
            model_d = 3'(MODEL_WASH_RINSE_SPIN);
            water_d = WATER_DEFAULT;
        end
    end

    assign power_light   = power_q;
    assign run_state     = state_q;
    assign current_model = model_q;
    assign current_water = water_q;
    assign buzzer        = buzzer_q;

endmodule

// File: tb/tb_panel_control.sv
// Scoreboard bench for panel_control with small debounce/hold/timeout values.
module tb_panel_control;

  localparam int unsigned     DEB  = 4;
  localparam int unsigned     HOLD = 8;
  localparam longint unsigned TMO  = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_key = 1'b0, start_key = 1'b0, model_key = 1'b0, water_key = 1'b0;
  logic       finish = 1'b0;
  logic       power_light, buzzer;
  logic [1:0] run_state;
  logic [2:0] current_model, current_water;

  panel_control #(.DEB_CYCLES(DEB), .DONE_HOLD(HOLD), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .power_key(power_key), .start_key(start_key),
    .model_key(model_key), .water_key(water_key),
    .finish(finish),
    .power_light(power_light), .run_state(run_state),
    .current_model(current_model), .current_water(current_water),
    .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    string       nm;
    logic        pl;
    logic [1:0]  rs;
    logic [2:0]  md;
    logic [2:0]  wt;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the expected outputs for k cycles from now (sampled on a falling edge).
  task automatic expect_at(input int unsigned k, input string nm, input logic pl,
                           input logic [1:0] rs, input logic [2:0] md,
                           input logic [2:0] wt, input logic bz);
    exp_t e;
    e.at = cyc + k; e.nm = nm; e.pl = pl; e.rs = rs; e.md = md; e.wt = wt; e.bz = bz;
    sb.push_back(e);
  endtask

  // Hold the selected raw keys for one debounce latency plus one, then release and settle.
  task automatic press(input logic [3:0] m, input string nm, input logic pl,
                       input logic [1:0] rs, input logic [2:0] md,
                       input logic [2:0] wt, input logic bz);
    {water_key, model_key, start_key, power_key} = m;
    expect_at(7, nm, pl, rs, md, wt, bz);
    tick(7);
    {water_key, model_key, start_key, power_key} = 4'b0000;
    tick(7);
  endtask

  // Monitor: pop every entry due this cycle and compare against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.at != cyc || power_light !== e.pl || run_state !== e.rs ||
            current_model !== e.md || current_water !== e.wt || buzzer !== e.bz) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (due %0d): got pl=%b rs=%0d md=%0d wt=%0d bz=%b, want pl=%b rs=%0d md=%0d wt=%0d bz=%b",
                   e.nm, cyc, e.at, power_light, run_state, current_model,
                   current_water, buzzer, e.pl, e.rs, e.md, e.wt, e.bz);
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(1);
    expect_at(1, "reset", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    tick(2);
    n_cmp++;
    if (power_light !== 1'b0 || run_state !== 2'd0 || current_model !== 3'd0 ||
        current_water !== 3'd2 || buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_direct: got pl=%b rs=%0d md=%0d wt=%0d bz=%b",
               power_light, run_state, current_model, current_water, buzzer);
    end
    rst_n = 1'b1;
    tick(1);

    // Bounce: 2-cycle pulses never reach the 4-sample threshold
    for (int unsigned i = 0; i < 6; i++) begin
      power_key = (i % 2 == 0);
      tick(2);
    end
    expect_at(1, "bounce_quiet", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    power_key = 1'b1;
    expect_at(6, "bounce_pre", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    expect_at(7, "bounce_on", 1'b1, 2'd0, 3'd0, 3'd2, 1'b0);
    tick(7);
    power_key = 1'b0;
    tick(7);

    // Selection wrap
    press(4'b0100, "model1", 1'b1, 2'd0, 3'd1, 3'd2, 1'b0);
    press(4'b0100, "model2", 1'b1, 2'd0, 3'd2, 3'd2, 1'b0);
    press(4'b0100, "model3", 1'b1, 2'd0, 3'd3, 3'd2, 1'b0);
    press(4'b0100, "model4", 1'b1, 2'd0, 3'd4, 3'd2, 1'b0);
    press(4'b0100, "model5", 1'b1, 2'd0, 3'd5, 3'd2, 1'b0);
    press(4'b0100, "model_wrap", 1'b1, 2'd0, 3'd0, 3'd2, 1'b0);
    press(4'b1000, "water3", 1'b1, 2'd0, 3'd0, 3'd3, 1'b0);
    press(4'b1000, "water4", 1'b1, 2'd0, 3'd0, 3'd4, 1'b0);
    press(4'b1000, "water5", 1'b1, 2'd0, 3'd0, 3'd5, 1'b0);
    press(4'b1000, "water_wrap", 1'b1, 2'd0, 3'd0, 3'd1, 1'b0);

    // Start and model together: start wins, model discarded
    press(4'b0110, "prio_start", 1'b1, 2'd1, 3'd0, 3'd1, 1'b0);
    press(4'b0010, "pause", 1'b1, 2'd2, 3'd0, 3'd1, 1'b0);
    press(4'b0010, "resume", 1'b1, 2'd1, 3'd0, 3'd1, 1'b0);
    press(4'b0100, "freeze_model", 1'b1, 2'd1, 3'd0, 3'd1, 1'b0);
    press(4'b0010, "pause2", 1'b1, 2'd2, 3'd0, 3'd1, 1'b0);

    // Finish ignored in PAUSE
    finish = 1'b1;
    expect_at(1, "pause_finish", 1'b1, 2'd2, 3'd0, 3'd1, 1'b0);
    tick(1);
    finish = 1'b0;
    tick(1);
    press(4'b0010, "resume2", 1'b1, 2'd1, 3'd0, 3'd1, 1'b0);

    // Finish coinciding with the start press pulse: DONE for exactly HOLD cycles
    start_key = 1'b1;
    expect_at(7, "done_enter", 1'b1, 2'd3, 3'd0, 3'd1, 1'b1);
    for (int unsigned k = 8; k <= 14; k++)
      expect_at(k, "done_hold", 1'b1, 2'd3, 3'd0, 3'd1, 1'b1);
    expect_at(15, "done_exit", 1'b1, 2'd0, 3'd0, 3'd1, 1'b0);
    tick(6);
    finish = 1'b1;
    tick(1);
    finish = 1'b0;
    start_key = 1'b0;
    tick(9);

    // Idle timeout after the last accepted press
    press(4'b0001, "pwr_off", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    press(4'b0001, "pwr_on", 1'b1, 2'd0, 3'd0, 3'd2, 1'b0);
    press(4'b0100, "tmo_model", 1'b1, 2'd0, 3'd1, 3'd2, 1'b0);
    water_key = 1'b1;
    expect_at(7, "tmo_water", 1'b1, 2'd0, 3'd1, 3'd3, 1'b0);
    expect_at(55, "tmo_pre", 1'b1, 2'd0, 3'd1, 3'd3, 1'b0);
    expect_at(56, "tmo_off", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    tick(7);
    water_key = 1'b0;
    tick(53);

    // Reset in the middle of RUN
    press(4'b0001, "pwr_on2", 1'b1, 2'd0, 3'd0, 3'd2, 1'b0);
    press(4'b0100, "m1", 1'b1, 2'd0, 3'd1, 3'd2, 1'b0);
    press(4'b0100, "m2", 1'b1, 2'd0, 3'd2, 3'd2, 1'b0);
    press(4'b0100, "m3", 1'b1, 2'd0, 3'd3, 3'd2, 1'b0);
    press(4'b0100, "m4", 1'b1, 2'd0, 3'd4, 3'd2, 1'b0);
    press(4'b1000, "w3", 1'b1, 2'd0, 3'd4, 3'd3, 1'b0);
    press(4'b1000, "w4", 1'b1, 2'd0, 3'd4, 3'd4, 1'b0);
    press(4'b1000, "w5", 1'b1, 2'd0, 3'd4, 3'd5, 1'b0);
    press(4'b0010, "run_mid", 1'b1, 2'd1, 3'd4, 3'd5, 1'b0);
    rst_n = 1'b0;
    expect_at(1, "rst_mid", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    tick(1);
    n_cmp++;
    if (power_light !== 1'b0 || run_state !== 2'd0 || current_model !== 3'd0 ||
        current_water !== 3'd2 || buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_direct: got pl=%b rs=%0d md=%0d wt=%0d bz=%b",
               power_light, run_state, current_model, current_water, buzzer);
    end
    rst_n = 1'b1;
    expect_at(2, "rst_after", 1'b0, 2'd0, 3'd0, 3'd2, 1'b0);
    tick(4);
    n_cmp++;
    if (power_light !== 1'b0 || run_state !== 2'd0 || current_model !== 3'd0 ||
        current_water !== 3'd2 || buzzer !== 1'b0) begin
      n_bad++;
      $display("FAIL settle_direct: got pl=%b rs=%0d md=%0d wt=%0d bz=%b",
               power_light, run_state, current_model, current_water, buzzer);
    end

    // Anything still queued was never compared
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation due at cyc %0d never checked (now %0d), want pl=%b rs=%0d",
               e.nm, e.at, cyc, e.pl, e.rs);
    end

    if (n_bad != 0)
      $display("FAIL: %0d mismatches", n_bad);
    else
      $display("PASS");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
